// File: rtl/demux32_1x32_bank.sv
// 32 x 32-bit register bank. Single writes and pointer-driven bursts both reach
// the storage through a 1-to-32 demux of D. Read-back is a combinational 32-to-1 mux.
module demux32_1x32_bank #(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] D,
  input  logic [4:0]  A,
  input  logic        WE,
  input  logic        BST,
  input  logic [4:0]  BLEN,
  input  logic [4:0]  RA,
  output logic [31:0] RD,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [31:0] mem_q [32];
  logic [31:0] mem_d [32];
  logic [0:0]  state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [4:0]  rem_q, rem_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        wr_en;
  logic [4:0]  wr_addr;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = A;

    case (state_q)
      S_IDLE: begin
        if (BST) begin
          // BST wins over WE; both target word[A], so it is written once.
          wr_en = 1'b1;
          ptr_d = A + 5'd1;
          rem_d = BLEN;
          if (BLEN != 5'd0) begin
            state_d = S_BURST;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end else if (WE) begin
          wr_en = 1'b1;
        end
      end
      default: begin
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        ptr_d   = ptr_q + 5'd1;
        rem_d   = rem_q - 5'd1;
        if (rem_q == 5'd1) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
    endcase
  end

  // Demux D onto the addressed word only; every other word recirculates.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      mem_d[i] = (wr_en && (wr_addr == 5'(i))) ? D : mem_q[i];
    end
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the storage words are reset too, since read-back must show RESET_VALUE right after reset.
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= RESET_VALUE;
      end
      state_q <= S_IDLE;
      ptr_q   <= 5'd0;
      rem_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign RD   = mem_q[RA];
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_demux32_1x32_bank.sv
// Scoreboard bench for demux32_1x32_bank: expectations are queued as stimulus
// is driven and popped when the DUT output is sampled 1ns after the edge.
module tb_demux32_1x32_bank;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] D;
  logic [4:0]  A;
  logic        WE;
  logic        BST;
  logic [4:0]  BLEN;
  logic [4:0]  RA;
  logic [31:0] RD;
  logic        BUSY;
  logic        DONE;

  demux32_1x32_bank dut (
    .CLK  (CLK),
    .RST  (RST),
    .D    (D),
    .A    (A),
    .WE   (WE),
    .BST  (BST),
    .BLEN (BLEN),
    .RA   (RA),
    .RD   (RD),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] exp_mem [32];
  logic [31:0] burst_data [$];
  int          total   = 0;
  int          bad     = 0;
  bit          started = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic compare_next(input logic [31:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, got, e.val);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_chk(input bit eb, input bit ed);
    expect_val("busy", {31'b0, eb});
    expect_val("done", {31'b0, ed});
    tick;
    compare_next({31'b0, BUSY});
    compare_next({31'b0, DONE});
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      RA = 5'(i);
      expect_val($sformatf("%s_rd%0d", tag, i), exp_mem[i]);
      #1;
      compare_next(RD);
    end
  endtask

  // Drives one whole burst from burst_data; noise toggles WE/BST/A/BLEN mid-burst.
  task automatic burst(input logic [4:0] a, input logic [4:0] blen,
                       input bit we_too, input bit noise);
    for (int k = 0; k <= int'(blen); k++) begin
      D = burst_data[k];
      if (k == 0) begin
        BST  = 1'b1;
        WE   = we_too;
        A    = a;
        BLEN = blen;
      end else begin
        BST  = noise;
        WE   = noise;
        A    = noise ? 5'd20 : a;
        BLEN = noise ? 5'd2 : blen;
      end
      exp_mem[5'(int'(a) + k)] = burst_data[k];
      tick_chk(k < int'(blen), k == int'(blen));
    end
    BST = 1'b0;
    WE  = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (started) chk("busy_done_excl", {31'b0, BUSY & DONE}, 32'd0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; D = '0; A = '0; WE = 1'b0; BST = 1'b0; BLEN = '0; RA = '0;
    repeat (2) tick;
    RST = 1'b0;
    started = 1'b1;
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'h0;
    sweep("rst");
    tick_chk(1'b0, 1'b0);

    // Single writes, with RD checked just before and just after each write edge.
    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); A = 5'(i); D = 32'(i); WE = 1'b1;
      expect_val($sformatf("pre_wr%0d", i), exp_mem[i]);
      #1;
      compare_next(RD);
      exp_mem[i] = 32'(i);
      tick_chk(1'b0, 1'b0);
      expect_val($sformatf("post_wr%0d", i), 32'(i));
      compare_next(RD);
    end
    WE = 1'b0;
    sweep("single");

    // Wrapping burst 30,31,0,1.
    burst_data = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h1, 32'h2};
    burst(5'd30, 5'd3, 1'b0, 1'b0);
    tick_chk(1'b0, 1'b0);
    sweep("wrap");

    // One-word burst.
    burst_data = '{32'hDEADBEEF};
    burst(5'd7, 5'd0, 1'b0, 1'b0);
    tick_chk(1'b0, 1'b0);
    sweep("len1");

    // BST+WE together, then noise on WE/A/BST during the burst.
    burst_data = '{32'h4444_0000, 32'h4444_0001, 32'h4444_0002, 32'h4444_0003};
    burst(5'd4, 5'd3, 1'b1, 1'b1);
    tick_chk(1'b0, 1'b0);
    sweep("prio");

    // Back-to-back bursts: second BST lands in the DONE cycle.
    burst_data = '{32'hB0B0_0010, 32'hB0B0_0011};
    burst(5'd10, 5'd1, 1'b0, 1'b0);
    burst_data = '{32'hC0C0_0012, 32'hC0C0_0013, 32'hC0C0_0014};
    burst(5'd12, 5'd2, 1'b0, 1'b0);
    tick_chk(1'b0, 1'b0);
    sweep("b2b");

    // Full 32-word burst from a mid address must touch every word once.
    burst_data.delete();
    for (int k = 0; k < 32; k++) burst_data.push_back($urandom);
    burst(5'd17, 5'd31, 1'b0, 1'b0);
    tick_chk(1'b0, 1'b0);
    sweep("full");

    // Reset five words into a 32-word burst.
    for (int k = 0; k < 5; k++) begin
      D = burst_data[k] ^ 32'hFFFF_0000;
      BST = (k == 0); A = 5'd0; BLEN = 5'd31;
      exp_mem[k] = D;
      tick_chk(1'b1, 1'b0);
    end
    RST = 1'b1; BST = 1'b0;
    tick_chk(1'b0, 1'b0);
    RST = 1'b0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'h0;
    sweep("midrst");
    burst_data = '{32'h3333_0003, 32'h3333_0004, 32'h3333_0005};
    burst(5'd3, 5'd2, 1'b0, 1'b0);
    tick_chk(1'b0, 1'b0);
    sweep("post_rst");

    if (sb_q.size() != 0) chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux32_1x32_bank.md
DEMUX32_1X32_BANK -- requirements
Module: demux32_1x32_bank

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter: RESET_VALUE, 32'h00000000, value loaded into every storage word on reset.
REQ-003 Port: CLK  input  1  clock; all state SHALL update on the rising edge only.
REQ-004 Port: RST  input  1  synchronous active-high reset.
REQ-005 Port: D  input  32  write data word.
REQ-006 Port: A  input  5  single-write address, or burst start address.
REQ-007 Port: WE  input  1  single-write strobe.
REQ-008 Port: BST  input  1  burst start strobe.
REQ-009 Port: BLEN  input  5  burst length minus one; a burst writes BLEN+1 words (1..32).
REQ-010 Port: RA  input  5  read-back select.
REQ-011 Port: RD  output  32  read-back data, combinational from the stored word selected by RA (32-to-1 selection of stored words).
REQ-012 Port: BUSY  output  1  registered; high while in BURST.
REQ-013 Port: DONE  output  1  registered; one-cycle pulse after the final write of a burst.

Function
REQ-014 The block SHALL hold 32 words of 32 bits, written through a 1-to-32 demultiplexer of D onto the addressed word.
REQ-015 States SHALL be IDLE and BURST; each edge SHALL write at most one word.
REQ-016 IDLE, BST=1: write word[A]=D; ptr<=A+1 mod 32; rem<=BLEN; next state BURST if BLEN!=0, else IDLE with DONE=1 next cycle.
REQ-017 IDLE, BST=0, WE=1: write word[A]=D; stay IDLE; DONE SHALL stay 0.
REQ-018 IDLE, BST=1 and WE=1 together: BST SHALL take priority; the write to word[A] SHALL occur once only.
REQ-019 BURST: each edge write word[ptr]=D; ptr<=ptr+1 mod 32; rem<=rem-1; when rem==1 at the edge, go to IDLE and pulse DONE for exactly one cycle.
REQ-020 BURST: WE, BST, A and BLEN SHALL be ignored.
REQ-021 Address wrap: ptr SHALL wrap 31->0; a 32-word burst from any A SHALL write every word exactly once.
REQ-022 Latency: a word written at edge N SHALL appear on RD (RA selecting it) after edge N; RD SHALL have no write-through bypass.
REQ-023 BUSY SHALL be 1 in the cycles after the start edge until the cycle after the final write edge; DONE and BUSY SHALL never be 1 together.
REQ-024 A new BST SHALL be accepted in the same cycle DONE is high, giving back-to-back bursts.
REQ-025 Words not addressed SHALL hold their value; X/Z on D SHALL only affect the addressed word.

Reset
REQ-026 RST=1 at an edge SHALL set all 32 words to RESET_VALUE, state to IDLE, ptr and rem to 0, and BUSY and DONE to 0.
REQ-027 RST SHALL take priority over WE, BST and any burst in progress; a burst interrupted by reset SHALL be abandoned without a DONE pulse.
REQ-028 RD SHALL equal RESET_VALUE for every RA in the cycle after reset.

Verification
REQ-029 Reset, then sweep RA=0..31 -> RD=32'h00000000 for every address.
REQ-030 WE=1 with A=i and D=i for i=0..31, then sweep RA -> RD=i for each i; BUSY=0 and DONE=0 throughout.
REQ-031 BST with A=30, BLEN=3, D=32'hA5A5A5A5 then 32'h5A5A5A5A then 1 then 2 -> words 30,31,0,1 hold those values; BUSY high 3 cycles; DONE pulses once; word 2 unchanged.
REQ-032 BST with BLEN=0, A=7, D=32'hDEADBEEF -> only word 7 written; BUSY stays 0; DONE pulses the next cycle.
REQ-033 BST and WE together with A=4, then WE pulses during the burst with A=20 -> word 20 unchanged; burst writes word 4 first.
REQ-034 RST asserted mid-burst (A=0, BLEN=31) after 5 words -> all words at RESET_VALUE; BUSY=0; no DONE pulse; a new burst starting next cycle completes normally.
